// File: rtl/word_sink_queue.sv
// word_sink_queue: ready/valid circular FIFO that terminates the 32-bit word link in registers
module word_sink_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_enq_valid,
  output logic                   io_enq_ready,
  input  logic [WIDTH-1:0]       io_enq_bits,
  output logic                   io_deq_valid,
  input  logic                   io_deq_ready,
  output logic [WIDTH-1:0]       io_deq_bits,
  input  logic                   io_flush,
  output logic [$clog2(DEPTH):0] io_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic enq_fire, deq_fire;
  // Full/empty come from the count alone, so equal pointers are never ambiguous.
  always_comb begin
    io_enq_ready = count_q != CW'(DEPTH);
    io_deq_valid = count_q != '0;
    enq_fire = io_enq_valid & io_enq_ready;
    deq_fire = io_deq_valid & io_deq_ready;
    wr_ptr_d = io_flush ? '0 : enq_fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = io_flush ? '0 : deq_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = io_flush ? '0 : count_q + CW'(enq_fire) - CW'(deq_fire);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (enq_fire && !io_flush) mem_q[wr_ptr_q] <= io_enq_bits;
  end
  assign io_deq_bits = mem_q[rd_ptr_q];
  assign io_count = count_q;
endmodule

// File: tb/tb_word_sink_queue.sv
// tb_word_sink_queue: scoreboard bench with a queue-based reference of FIFO contents
module tb_word_sink_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic io_enq_valid = 1'b0;
  logic io_deq_ready = 1'b0;
  logic io_flush = 1'b0;
  logic [WIDTH-1:0] io_enq_bits = '0;
  logic io_enq_ready, io_deq_valid;
  logic [WIDTH-1:0] io_deq_bits;
  logic [$clog2(DEPTH):0] io_count;
  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q [$];
  bit enq_took;
  always #5 clock = ~clock;
  word_sink_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .io_enq_valid(io_enq_valid),
    .io_enq_ready(io_enq_ready),
    .io_enq_bits(io_enq_bits),
    .io_deq_valid(io_deq_valid),
    .io_deq_ready(io_deq_ready),
    .io_deq_bits(io_deq_bits),
    .io_flush(io_flush),
    .io_count(io_count)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  // Monitor: compare against the reference contents, then apply this cycle's handshakes to it.
  always @(negedge clock) begin
    chk("enq_ready", {31'd0, io_enq_ready}, {31'd0, exp_q.size() != DEPTH});
    chk("deq_valid", {31'd0, io_deq_valid}, {31'd0, exp_q.size() != 0});
    chk("count", 32'(io_count), 32'(exp_q.size()));
    if (!reset) begin
      exp_q.delete();
      enq_took = 1'b0;
    end else begin
      if (exp_q.size() != 0) chk("deq_bits", io_deq_bits, exp_q[0]);
      enq_took = io_enq_valid && exp_q.size() != DEPTH;
      if (io_flush) exp_q.delete();
      else begin
        if (io_deq_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (enq_took) exp_q.push_back(io_enq_bits);
      end
    end
  end
  task automatic cyc(logic ev, logic [31:0] eb, logic dr, logic fl);
    @(posedge clock);
    #1;
    io_enq_valid = ev;
    io_enq_bits = eb;
    io_deq_ready = dr;
    io_flush = fl;
  endtask
  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    cyc(0, 0, 0, 0);
    foreach (exp_q[i]) chk("reset_empty", 32'(i), 32'hFFFF_FFFF);
    for (int i = 1; i <= 4; i++) cyc(1, 32'(i * 'h11), 0, 0);
    cyc(1, 32'h99, 0, 0);
    chk("fill_count", 32'(io_count), 32'd4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 32'hA1 + 32'(i), 0, 0);
    cyc(1, 32'h55, 1, 0);
    cyc(1, 32'h55, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 32'(i), 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'hB1 + 32'(i), 0, 0);
    cyc(1, 32'h77, 0, 1);
    cyc(1, 32'h88, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 32'hC1, 0, 0);
    cyc(1, 32'hC2, 0, 0);
    cyc(0, 0, 0, 0);
    @(posedge clock);
    #3 reset = 1'b0;
    exp_q.delete();
    #1;
    chk("async_deq_valid", {31'd0, io_deq_valid}, 32'd0);
    chk("async_count", 32'(io_count), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    cyc(1, 32'hAB, 0, 0);
    cyc(0, 0, 1, 0);
    chk("after_reset_first", io_deq_bits, 32'hAB);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      if (!(io_enq_valid && !enq_took)) begin
        io_enq_valid = $urandom_range(0, 3) != 0;
        io_enq_bits = $urandom;
      end
      io_deq_ready = $urandom_range(0, 2) != 0;
      io_flush = $urandom_range(0, 39) == 0;
    end
    cyc(0, 0, 1, 0);
    repeat (6) @(posedge clock);
    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
